// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared types and LFU opcode constants for the blitter LFU sequencer
package blit_pkg;

  // Sequencer states; one bus state per memory access plus a pointer-step state
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SRD  = 3'd1,
    ST_DRD  = 3'd2,
    ST_WR   = 3'd3,
    ST_STEP = 3'd4
  } state_t;

  // Common LFU minterm patterns, indexed as LFUC[{src_bit, dst_bit}]
  localparam logic [3:0] LFU_ZERO = 4'b0000;
  localparam logic [3:0] LFU_SRC  = 4'b1100;
  localparam logic [3:0] LFU_DST  = 4'b1010;
  localparam logic [3:0] LFU_XOR  = 4'b0110;
  localparam logic [3:0] LFU_OR   = 4'b1110;
  localparam logic [3:0] LFU_AND  = 4'b1000;
  localparam logic [3:0] LFU_NSRC = 4'b0011;

  // First bus state of an item: disabled reads are skipped
  function automatic state_t first_state(input logic srcen, input logic dsten);
    if (srcen) return ST_SRD;
    if (dsten) return ST_DRD;
    return ST_WR;
  endfunction

endpackage

// File: rtl/lfu_word.sv
// rtl/lfu_word.sv - word-wide logic function unit built from per-bit minterm selects
module lfu_word #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] SRCD,
  input  logic [DW-1:0] DSTD,
  input  logic [3:0]    LFUC,
  output logic [DW-1:0] DOUT
);

  // Each output bit picks the minterm enable addressed by its source/destination bit pair
  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign DOUT[i] = LFUC[{SRCD[i], DSTD[i]}];
  end

endmodule

// File: rtl/blit_lfu_seq.sv
// rtl/blit_lfu_seq.sv - blitter LFU sequencer: read/combine/write items over the memory handshake
module blit_lfu_seq
  import blit_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic          START,
  input  logic          ABORT,
  input  logic [3:0]    LFUC,
  input  logic          SRCEN,
  input  logic          DSTEN,
  input  logic          SDIR,
  input  logic          DDIR,
  input  logic [AW-1:0] SRCADDR,
  input  logic [AW-1:0] DSTADDR,
  input  logic [CW-1:0] COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          MREQ,
  output logic          MWR,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MDOUT,
  input  logic [DW-1:0] MDIN,
  input  logic          MACK
);

  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t        state, state_n;
  logic [3:0]    lfuc_q, lfuc_n;
  logic          srcen_q, srcen_n, dsten_q, dsten_n, sdir_q, sdir_n, ddir_q, ddir_n;
  logic [AW-1:0] sptr, sptr_n, dptr, dptr_n, sptr_step, dptr_step;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] sdat, sdat_n, ddat, ddat_n;
  logic          busy_n, done_n, mreq_n, mwr_n;
  logic [AW-1:0] maddr_n;
  logic [DW-1:0] mdout_n;
  logic [3:0]    lfu_c;
  logic [DW-1:0] lfu_s, lfu_d, lfu_out;

  // LFU operands: read data is bypassed on its ack edge so MDOUT can be registered entering WR
  always_comb begin
    lfu_c = (state == ST_IDLE) ? LFUC : lfuc_q;
    lfu_s = (state == ST_SRD) ? MDIN : ((state == ST_IDLE) ? '0 : sdat);
    lfu_d = (state == ST_DRD) ? MDIN : ((state == ST_IDLE) ? '0 : ddat);
  end

  lfu_word #(.DW(DW)) u_lfu (
    .SRCD(lfu_s),
    .DSTD(lfu_d),
    .LFUC(lfu_c),
    .DOUT(lfu_out)
  );

  // Next-state, datapath and registered bus output computation
  always_comb begin
    state_n   = state;
    lfuc_n    = lfuc_q;
    srcen_n   = srcen_q;
    dsten_n   = dsten_q;
    sdir_n    = sdir_q;
    ddir_n    = ddir_q;
    sptr_n    = sptr;
    dptr_n    = dptr;
    cnt_n     = cnt;
    sdat_n    = sdat;
    ddat_n    = ddat;
    mreq_n    = MREQ;
    mwr_n     = MWR;
    maddr_n   = MADDR;
    mdout_n   = MDOUT;
    done_n    = 1'b0;
    sptr_step = sdir_q ? (sptr - A_ONE) : (sptr + A_ONE);
    dptr_step = ddir_q ? (dptr - A_ONE) : (dptr + A_ONE);
    case (state)
      ST_IDLE: begin
        if (START) begin
          lfuc_n  = LFUC;
          srcen_n = SRCEN;
          dsten_n = DSTEN;
          sdir_n  = SDIR;
          ddir_n  = DDIR;
          sptr_n  = SRCADDR;
          dptr_n  = DSTADDR;
          cnt_n   = COUNT;
          sdat_n  = '0;
          ddat_n  = '0;
          state_n = first_state(SRCEN, DSTEN);
          mreq_n  = 1'b1;
          mwr_n   = (state_n == ST_WR);
          maddr_n = SRCEN ? SRCADDR : DSTADDR;
          mdout_n = lfu_out;
        end
      end
      ST_SRD: begin
        if (MACK) begin
          sdat_n  = MDIN;
          state_n = dsten_q ? ST_DRD : ST_WR;
          mwr_n   = !dsten_q;
          maddr_n = dptr;
          mdout_n = lfu_out;
        end
      end
      ST_DRD: begin
        if (MACK) begin
          ddat_n  = MDIN;
          state_n = ST_WR;
          mwr_n   = 1'b1;
          mdout_n = lfu_out;
        end
      end
      ST_WR: begin
        if (MACK) begin
          state_n = ST_STEP;
          mreq_n  = 1'b0;
          mwr_n   = 1'b0;
        end
      end
      ST_STEP: begin
        if ((cnt == C_ONE) || ABORT) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n   = cnt - C_ONE;
          sptr_n  = sptr_step;
          dptr_n  = dptr_step;
          state_n = first_state(srcen_q, dsten_q);
          mreq_n  = 1'b1;
          mwr_n   = (state_n == ST_WR);
          maddr_n = srcen_q ? sptr_step : dptr_step;
          mdout_n = lfu_out;
        end
      end
      default: begin
        state_n = ST_IDLE;
        mreq_n  = 1'b0;
        mwr_n   = 1'b0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State, latched programming, pointers, data and bus outputs
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state   <= ST_IDLE;
      lfuc_q  <= '0;
      srcen_q <= 1'b0;
      dsten_q <= 1'b0;
      sdir_q  <= 1'b0;
      ddir_q  <= 1'b0;
      sptr    <= '0;
      dptr    <= '0;
      cnt     <= '0;
      sdat    <= '0;
      ddat    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      MREQ    <= 1'b0;
      MWR     <= 1'b0;
      MADDR   <= '0;
      MDOUT   <= '0;
    end else begin
      state   <= state_n;
      lfuc_q  <= lfuc_n;
      srcen_q <= srcen_n;
      dsten_q <= dsten_n;
      sdir_q  <= sdir_n;
      ddir_q  <= ddir_n;
      sptr    <= sptr_n;
      dptr    <= dptr_n;
      cnt     <= cnt_n;
      sdat    <= sdat_n;
      ddat    <= ddat_n;
      BUSY    <= busy_n;
      DONE    <= done_n;
      MREQ    <= mreq_n;
      MWR     <= mwr_n;
      MADDR   <= maddr_n;
      MDOUT   <= mdout_n;
    end
  end

endmodule
